// File: rtl/icsp_prog_loader.sv
// icsp_prog_loader: serial in-circuit programming front end.
// Receives PIC-style ICSP commands on pgc/pgd and drives the instruction
// memory write port. It holds the CPU core in reset while program mode is on.
//
// Ports:
//   clk, rst        system clock, asynchronous active-low reset
//   prog_en         program-mode enable (level)
//   pgc, pgd        serial clock / data, asynchronous to clk
//   wr_en           one-cycle memory write strobe
//   wr_addr         current program address
//   wr_data         latched instruction word
//   cpu_hold        core reset hold, registered prog_en
//   busy            high for PROG_CYCLES clk after each write strobe
//   rd_req          readback request strobe           (PROG_READBACK_EN)
//   rd_data         memory read data                  (PROG_READBACK_EN)
//   pgd_out, pgd_oe serial readback data / enable     (PROG_READBACK_EN)
//
// Optional feature: define PROG_READBACK_EN to decode the Read Data command
// (0x04). Without it, 0x04 is ignored and the readback outputs are tied to 0.
module icsp_prog_loader #(
  parameter int unsigned ADDR_WIDTH  = 13,
  parameter int unsigned INSTR_WIDTH = 14,
  parameter int unsigned PROG_CYCLES = 8,
  parameter int unsigned RD_LATENCY  = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   prog_en,
  input  logic                   pgc,
  input  logic                   pgd,
  output logic                   wr_en,
  output logic [ADDR_WIDTH-1:0]  wr_addr,
  output logic [INSTR_WIDTH-1:0] wr_data,
  output logic                   cpu_hold,
  output logic                   busy,
  output logic                   rd_req,
  input  logic [INSTR_WIDTH-1:0] rd_data,
  output logic                   pgd_out,
  output logic                   pgd_oe
);

  localparam int unsigned CMD_BITS   = 6;
  localparam int unsigned FRAME_BITS = INSTR_WIDTH + 2;
  // The start bit is shifted out by the end of a data frame, so one bit less is kept.
  localparam int unsigned SR_W       = FRAME_BITS - 1;
  localparam int unsigned CNT_W      = $clog2(FRAME_BITS + 1);
  localparam int unsigned BUSY_W     = $clog2(PROG_CYCLES + 1);

  localparam logic [CMD_BITS-1:0] CMD_LOAD = 6'h02;
  localparam logic [CMD_BITS-1:0] CMD_INC  = 6'h06;
  localparam logic [CMD_BITS-1:0] CMD_PROG = 6'h08;
  localparam logic [CMD_BITS-1:0] CMD_RST  = 6'h16;
`ifdef PROG_READBACK_EN
  localparam logic [CMD_BITS-1:0] CMD_READ = 6'h04;
  localparam int unsigned         RD_W     = $clog2(RD_LATENCY + 2);
`endif

  typedef enum logic [2:0] {
    ST_CMD   = 3'd0,
    ST_LOAD  = 3'd1,
    ST_WRITE = 3'd2,
`ifdef PROG_READBACK_EN
    ST_WAIT  = 3'd3,
    ST_READ  = 3'd4
`else
    ST_WAIT  = 3'd3
`endif
  } state_t;

  state_t              state_q, state_d;
  logic [1:0]          pgc_sync, pgd_sync;
  logic                pgc_prev;
  logic                prog_en_q;
  logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic [SR_W-1:0]     sr_q, sr_d;
  logic [BUSY_W-1:0]   busy_cnt_q, busy_cnt_d;
  logic [ADDR_WIDTH-1:0]  wr_addr_d;
  logic [INSTR_WIDTH-1:0] wr_data_d;
  logic                wr_en_d;
  logic                busy_d;
  logic                pgc_rise;
  logic [CMD_BITS-1:0] cmd;

`ifdef PROG_READBACK_EN
  logic [RD_W-1:0]        rd_cnt_q, rd_cnt_d;
  logic [INSTR_WIDTH:0]   tx_q, tx_d;
  logic                   rd_req_d, pgd_out_d, pgd_oe_d;
`else
  logic unused_rd_data;
  assign unused_rd_data = ^rd_data;
  assign rd_req  = 1'b0;
  assign pgd_out = 1'b0;
  assign pgd_oe  = 1'b0;
`endif

  // Bit sample strobe: rising edge of the synchronised pgc.
  assign pgc_rise = pgc_sync[1] & ~pgc_prev;
  // LSB-first shift leaves the six command bits at the top of the register.
  assign cmd      = sr_q[SR_W-1 -: CMD_BITS];
  assign cpu_hold = prog_en_q;

  // Next-state, datapath and output logic.
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    sr_d       = sr_q;
    wr_addr_d  = wr_addr;
    wr_data_d  = wr_data;
    wr_en_d    = 1'b0;
    busy_cnt_d = busy_cnt_q;
`ifdef PROG_READBACK_EN
    rd_req_d   = 1'b0;
    rd_cnt_d   = rd_cnt_q;
    tx_d       = tx_q;
    pgd_out_d  = pgd_out;
    pgd_oe_d   = pgd_oe;
`endif

    // Write-recovery countdown; it keeps running even if program mode drops.
    if (wr_en) begin
      busy_cnt_d = BUSY_W'(PROG_CYCLES);
    end else if (busy_cnt_q != '0) begin
      busy_cnt_d = busy_cnt_q - BUSY_W'(1);
    end

    if (prog_en_q) begin
      case (state_q)
        ST_CMD: begin
          if (bit_cnt_q == CNT_W'(CMD_BITS)) begin
            bit_cnt_d = '0;
            case (cmd)
              CMD_LOAD: state_d = ST_LOAD;
              CMD_INC:  wr_addr_d = wr_addr + ADDR_WIDTH'(1);
              CMD_PROG: begin
                if (!busy) begin
                  wr_en_d = 1'b1;
                  state_d = ST_WRITE;
                end
              end
              CMD_RST:  wr_addr_d = '0;
`ifdef PROG_READBACK_EN
              CMD_READ: begin
                rd_req_d = 1'b1;
                rd_cnt_d = RD_W'(RD_LATENCY + 1);
                state_d  = ST_READ;
              end
`endif
              default: ;
            endcase
          end else if (pgc_rise) begin
            sr_d      = {pgd_sync[1], sr_q[SR_W-1:1]};
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
          end
        end
        ST_LOAD: begin
          if (bit_cnt_q == CNT_W'(FRAME_BITS)) begin
            wr_data_d = sr_q[INSTR_WIDTH-1:0];
            bit_cnt_d = '0;
            state_d   = ST_CMD;
          end else if (pgc_rise) begin
            sr_d      = {pgd_sync[1], sr_q[SR_W-1:1]};
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
          end
        end
        ST_WRITE: state_d = ST_WAIT;
        ST_WAIT:  state_d = ST_CMD;
`ifdef PROG_READBACK_EN
        ST_READ: begin
          if (rd_cnt_q != '0) begin
            // Memory data is captured once the read latency has elapsed;
            // the start bit goes out at the same time.
            rd_cnt_d = rd_cnt_q - RD_W'(1);
            if (rd_cnt_q == RD_W'(1)) begin
              tx_d      = {1'b0, rd_data};
              pgd_out_d = 1'b0;
              pgd_oe_d  = 1'b1;
            end
          end else if (pgc_rise) begin
            if (bit_cnt_q == CNT_W'(FRAME_BITS - 1)) begin
              pgd_out_d = 1'b0;
              pgd_oe_d  = 1'b0;
              bit_cnt_d = '0;
              state_d   = ST_CMD;
            end else begin
              pgd_out_d = tx_q[0];
              tx_d      = tx_q >> 1;
              bit_cnt_d = bit_cnt_q + CNT_W'(1);
            end
          end
        end
`endif
        default: state_d = ST_CMD;
      endcase
    end else begin
      // Out of program mode: abort any frame and ignore pgc.
      state_d   = ST_CMD;
      bit_cnt_d = '0;
`ifdef PROG_READBACK_EN
      rd_cnt_d  = '0;
      pgd_out_d = 1'b0;
      pgd_oe_d  = 1'b0;
`endif
    end

    if (prog_en && !prog_en_q) begin
      wr_addr_d = '0;
    end

    busy_d = (busy_cnt_d != '0);
  end

  // State, synchronisers and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_CMD;
      pgc_sync   <= '0;
      pgd_sync   <= '0;
      pgc_prev   <= 1'b0;
      prog_en_q  <= 1'b0;
      bit_cnt_q  <= '0;
      sr_q       <= '0;
      busy_cnt_q <= '0;
      wr_addr    <= '0;
      wr_data    <= '0;
      wr_en      <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state_q    <= state_d;
      pgc_sync   <= {pgc_sync[0], pgc};
      pgd_sync   <= {pgd_sync[0], pgd};
      pgc_prev   <= pgc_sync[1];
      prog_en_q  <= prog_en;
      bit_cnt_q  <= bit_cnt_d;
      sr_q       <= sr_d;
      busy_cnt_q <= busy_cnt_d;
      wr_addr    <= wr_addr_d;
      wr_data    <= wr_data_d;
      wr_en      <= wr_en_d;
      busy       <= busy_d;
    end
  end

`ifdef PROG_READBACK_EN
  // Readback registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_cnt_q <= '0;
      tx_q     <= '0;
      rd_req   <= 1'b0;
      pgd_out  <= 1'b0;
      pgd_oe   <= 1'b0;
    end else begin
      rd_cnt_q <= rd_cnt_d;
      tx_q     <= tx_d;
      rd_req   <= rd_req_d;
      pgd_out  <= pgd_out_d;
      pgd_oe   <= pgd_oe_d;
    end
  end
`endif

endmodule
